// File: rtl/svc_soc_uart_rx_reg.sv
// UART receiver (8N1) with RX FIFO and DATA/STATUS io registers.
// Define SVC_UART_RX_PARITY_EN for 8E1 framing with parity checking.
module svc_soc_uart_rx_reg #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        urx_pin,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    output logic        rx_irq
);
    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW       = PTR_W + 1;
    localparam logic [31:0] STATUS_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(CLKS_PER_BIT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    state_e           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             push_q, frame_set_q, par_set_q;
`ifdef SVC_UART_RX_PARITY_EN
    logic             par_acc_q, par_bad_q;
`endif

    logic             rx_fall, baud_exp;
    assign rx_fall  = rx_prev_q & ~rx_s2_q;
    assign baud_exp = (baud_q == CNT_W'(1));

    // Preset to idle-high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= urx_pin;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            push_q      <= 1'b0;
            frame_set_q <= 1'b0;
            par_set_q   <= 1'b0;
`ifdef SVC_UART_RX_PARITY_EN
            par_acc_q   <= 1'b0;
            par_bad_q   <= 1'b0;
`endif
        end else begin
            push_q      <= 1'b0;
            frame_set_q <= 1'b0;
            par_set_q   <= 1'b0;
            if (state_q != S_IDLE && state_q != S_BREAK && !baud_exp) begin
                baud_q <= baud_q - 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (rx_fall) begin
                        state_q <= S_START;
                        baud_q  <= BAUD_HALF;
                    end
                end
                S_START: begin
                    if (baud_exp) begin
                        if (!rx_s2_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                            baud_q    <= BAUD_FULL;
`ifdef SVC_UART_RX_PARITY_EN
                            par_acc_q <= 1'b0;
`endif
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (baud_exp) begin
                        baud_q    <= BAUD_FULL;
                        bit_idx_q <= bit_idx_q + 1'b1;
`ifdef SVC_UART_RX_PARITY_EN
                        par_acc_q <= par_acc_q ^ rx_s2_q;
                        if (bit_idx_q == 3'd7) state_q <= S_PARITY;
`else
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
`endif
                    end
                end
`ifdef SVC_UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_exp) begin
                        par_bad_q <= par_acc_q ^ rx_s2_q;
                        baud_q    <= BAUD_FULL;
                        state_q   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_exp) begin
                        if (rx_s2_q) begin
                            state_q <= S_IDLE;
`ifdef SVC_UART_RX_PARITY_EN
                            if (par_bad_q) par_set_q <= 1'b1;
                            else           push_q    <= 1'b1;
`else
                            push_q  <= 1'b1;
`endif
                        end else begin
                            frame_set_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s2_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Shift register only moves while sampling data bits; it is the push payload.
    always_ff @(posedge clk) begin
        if (state_q == S_DATA && baud_exp) shift_q <= {rx_s2_q, shift_q[7:1]};
    end

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_FW-1:0] count_q, count_d;
    logic              ovr_q, fe_q, pe_q;
    logic [31:0]       io_rdata_q, rdata_d, status_w;
    logic              rx_irq_q;
    logic              empty, full, rd_data_hit, rd_stat_hit, pop, push_ok, ovr_set, wr_clr;
    logic [15:0]       count16;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_FW'(FIFO_DEPTH));
    assign rd_data_hit = io_ren && (io_raddr == BASE_ADDR);
    assign rd_stat_hit = io_ren && (io_raddr == STATUS_ADDR);
    assign pop         = rd_data_hit && !empty;
    assign push_ok     = push_q && (!full || pop);
    assign ovr_set     = push_q && full && !pop;
    assign wr_clr      = io_wen && (io_waddr == STATUS_ADDR) && io_wstrb[0];
    assign count16     = 16'(count_q);
    assign status_w    = {8'b0, count16, 4'b0, pe_q, fe_q, ovr_q, !empty};

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        rdata_d = io_rdata_q;
        if (io_ren) begin
            rdata_d = '0;
            if (pop)              rdata_d = {24'b0, mem_q[rd_ptr_q]};
            else if (rd_stat_hit) rdata_d = status_w;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            io_rdata_q <= '0;
            rx_irq_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            rx_irq_q   <= (count_d != '0);
            io_rdata_q <= rdata_d;
            ovr_q <= (ovr_q & ~(wr_clr & io_wdata[1])) | ovr_set;
            fe_q  <= (fe_q  & ~(wr_clr & io_wdata[2])) | frame_set_q;
            pe_q  <= (pe_q  & ~(wr_clr & io_wdata[3])) | par_set_q;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{io_wdata[31:4], io_wdata[0], io_wstrb[3:1]};

    assign io_rdata = io_rdata_q;
    assign rx_irq   = rx_irq_q;
endmodule

// File: tb/tb_svc_soc_uart_rx_reg.sv
// Self-checking bench for svc_soc_uart_rx_reg at 10 clocks per bit.
`timescale 1ns/1ps
module tb_svc_soc_uart_rx_reg;
    localparam int unsigned CPB  = 10;
    localparam logic [31:0] BASE = 32'h8000_0010;
    localparam logic [31:0] STAT = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        rst, urx_pin, io_ren, io_wen, rx_irq;
    logic [31:0] io_raddr, io_rdata, io_waddr, io_wdata;
    logic [3:0]  io_wstrb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    svc_soc_uart_rx_reg #(
        .CLOCK_FREQ(10_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH(16), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .urx_pin(urx_pin), .io_ren(io_ren), .io_raddr(io_raddr),
        .io_rdata(io_rdata), .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
        .io_wstrb(io_wstrb), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic        exp_irq;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        io_raddr = addr;
        io_ren   = 1'b1;
        wait_clks(1);
        io_ren   = 1'b0;
        check(name, io_rdata, exp_q.pop_front());
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        io_waddr = addr;
        io_wdata = data;
        io_wstrb = strb;
        io_wen   = 1'b1;
        wait_clks(1);
        io_wen   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        urx_pin = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
    endtask

    // stop_low > 0 holds the stop bit low that many clocks; pop_at_stop issues a DATA
    // read in the cycle the received byte lands in the FIFO; abort_bit >= 0 resets mid-frame.
    task automatic send_frame(input logic [7:0] b, input int stop_low, input bit pop_at_stop,
                              input logic [7:0] pop_exp, input int abort_bit);
        logic [10:0] bits;
        int nb;
        bits = '0;
        bits[8:1] = b;
`ifdef SVC_UART_RX_PARITY_EN
        bits[9] = ^b;
        nb = 10;
`else
        nb = 9;
`endif
        for (int i = 0; i < nb; i++) begin
            urx_pin = bits[i];
            if (i == abort_bit) begin
                wait_clks(3);
                rst = 1'b1;
                wait_clks(1);
                check("rdata_in_reset", io_rdata, 32'h0);
                check("irq_in_reset", {31'b0, rx_irq}, 32'h0);
                wait_clks(2);
                rst = 1'b0;
                urx_pin = 1'b1;
                wait_clks(2 * CPB);
                return;
            end
            wait_clks(CPB);
        end
        if (stop_low > 0) begin
            urx_pin = 1'b0;
            wait_clks(stop_low);
            urx_pin = 1'b1;
            wait_clks(CPB);
        end else begin
            urx_pin = 1'b1;
            if (pop_at_stop) begin
                wait_clks(CPB - 2);
                io_read(BASE, {24'b0, pop_exp}, "pop_at_stop");
                wait_clks(1);
            end else begin
                wait_clks(CPB);
            end
        end
        wait_clks(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1'b0, STAT,              32'h0,  4'h0, 32'h0000_0201, 1'b1, "s1_status"};
        vecs[1] = '{1'b0, BASE + 32'd8,      32'h0,  4'h0, 32'h0000_0000, 1'b1, "s1_other_addr"};
        vecs[2] = '{1'b1, BASE,              32'hFF, 4'hF, 32'h0,         1'b1, "s1_wr_data"};
        vecs[3] = '{1'b0, BASE,              32'h0,  4'h0, 32'h0000_0055, 1'b1, "s1_data0"};
        vecs[4] = '{1'b0, BASE,              32'h0,  4'h0, 32'h0000_00A3, 1'b0, "s1_data1"};
        vecs[5] = '{1'b0, BASE,              32'h0,  4'h0, 32'h0000_0000, 1'b0, "s1_data_empty"};
        vecs[6] = '{1'b0, STAT,              32'h0,  4'h0, 32'h0000_0000, 1'b0, "s1_status_end"};

        io_ren = 1'b0; io_wen = 1'b0; io_raddr = '0; io_waddr = '0; io_wdata = '0; io_wstrb = '0;
        rst = 1'b1;
        urx_pin = 1'b1;
        wait_clks(3);
        check("reset_rdata", io_rdata, 32'h0);
        check("reset_irq", {31'b0, rx_irq}, 32'h0);
        rst = 1'b0;
        wait_clks(2);
        io_read(STAT, 32'h0, "reset_status");

        send_frame(8'h55, 0, 1'b0, 8'h00, -1);
        send_frame(8'hA3, 0, 1'b0, 8'h00, -1);
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].we) io_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            else            io_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
            check({vecs[i].name, "_irq"}, {31'b0, rx_irq}, {31'b0, vecs[i].exp_irq});
        end

        urx_pin = 1'b0;
        wait_clks(3);
        urx_pin = 1'b1;
        wait_clks(3 * CPB);
        io_read(STAT, 32'h0, "glitch_status");

        send_frame(8'h41, 20, 1'b0, 8'h00, -1);
        io_read(STAT, 32'h0000_0004, "frame_err_status");
        io_write(STAT, 32'h4, 4'b1110);
        io_read(STAT, 32'h0000_0004, "w1c_no_strb0");
        io_write(STAT, 32'h4, 4'b0001);
        io_read(STAT, 32'h0000_0000, "w1c_cleared");
        send_frame(8'h42, 0, 1'b0, 8'h00, -1);
        io_read(STAT, 32'h0000_0101, "after_fe_status");
        io_read(BASE, 32'h0000_0042, "after_fe_data");

        for (int i = 0; i < 17; i++) send_frame(8'(i), 0, 1'b0, 8'h00, -1);
        io_read(STAT, 32'h0000_1003, "overrun_status");
        for (int i = 0; i < 16; i++) io_read(BASE, 32'(i), "overrun_data");
        io_read(STAT, 32'h0000_0002, "overrun_sticky");
        io_write(STAT, 32'h2, 4'b0001);
        io_read(STAT, 32'h0000_0000, "overrun_cleared");

        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 0, 1'b0, 8'h00, -1);
        send_frame(8'h10, 0, 1'b1, 8'h00, -1);
        io_read(STAT, 32'h0000_1001, "full_pop_status");
        for (int i = 1; i <= 16; i++) io_read(BASE, 32'(i), "full_pop_data");
        check("full_pop_irq", {31'b0, rx_irq}, 32'h0);

        send_frame(8'h7E, 0, 1'b0, 8'h00, 5);
        send_frame(8'h33, 0, 1'b0, 8'h00, -1);
        io_read(STAT, 32'h0000_0101, "midreset_status");
        io_read(BASE, 32'h0000_0033, "midreset_data");
        io_read(BASE, 32'h0000_0000, "midreset_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
